// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants, fault codes and fetch-state type
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
   localparam logic [1:0]  FAULT_RANGE    = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } fetch_state_e;

   // A misaligned PC is reported even when it is also out of range.
   function automatic logic [1:0] fetch_fault(input logic misalign, input logic out_of_range);
      if (misalign)
         return FAULT_MISALIGN;
      else if (out_of_range)
         return FAULT_RANGE;
      else
         return FAULT_NONE;
   endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x DATA_WIDTH instruction storage, one clocked write port, one read port
module imem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 128,
   localparam int IDX_W     = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Contents survive reset; the array is filled only through the write port.
   always_ff @(posedge clk_i) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - instruction memory with fetch handshake, access latency, program port and faults
module instr_fetch_mem
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 128,
   parameter int LATENCY    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_instr,
   output logic [1:0]               rsp_fault,
   input  logic                     flush,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [DATA_WIDTH-1:0]    prog_wdata
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   fetch_state_e          state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic [1:0]            fault_q;

   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  misalign;
   logic                  out_of_range;
   logic                  accept;
   logic [1:0]            fault_d;
   logic [DATA_WIDTH-1:0] instr_d;

   imem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_imem (
      .clk_i   (clk),
      .we_i    (prog_we),
      .waddr_i (prog_addr),
      .wdata_i (prog_wdata),
      .raddr_i (rd_idx),
      .rdata_o (rd_data)
   );

   assign rd_idx       = req_addr[2 +: IDX_W];
   assign misalign     = |req_addr[1:0];
   assign out_of_range = |(req_addr >> (2 + IDX_W));
   assign fault_d      = fetch_fault(misalign, out_of_range);
   assign instr_d      = (fault_d == FAULT_NONE) ? rd_data : DATA_WIDTH'(NOP_INSTR);

   assign req_ready = !flush && (state_q == IDLE || (state_q == RESP && rsp_ready));
   assign accept    = req_valid && req_ready;

   assign rsp_valid = (state_q == RESP);
   assign rsp_instr = instr_q;
   assign rsp_fault = fault_q;

   // Capturing on the accept edge gives read-before-write against a same-edge program write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         instr_q <= '0;
         fault_q <= FAULT_NONE;
      end else if (flush) begin
         state_q <= IDLE;
      end else if (accept) begin
         instr_q <= instr_d;
         fault_q <= fault_d;
         if (LATENCY == 1) begin
            state_q <= RESP;
         end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_LOAD;
         end
      end else begin
         case (state_q)
            WAIT: begin
               if (cnt_q == '0)
                  state_q <= RESP;
               else
                  cnt_q <= cnt_q - 1'b1;
            end
            RESP: begin
               if (rsp_ready)
                  state_q <= IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - scoreboard bench for instr_fetch_mem at LATENCY 1 (a_*) and LATENCY 3 (b_*)
module tb_instr_fetch_mem;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 128;
   localparam int IW = 7;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_flush, a_prog_we;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_rsp_instr, a_prog_wdata;
   logic [1:0]    a_rsp_fault;
   logic [IW-1:0] a_prog_addr;

   logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_flush, b_prog_we;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_rsp_instr, b_prog_wdata;
   logic [1:0]    b_rsp_fault;
   logic [IW-1:0] b_prog_addr;

   logic [33:0] a_exp_q[$];
   logic [33:0] b_exp_q[$];
   logic [33:0] exp_v;
   int pass_cnt = 0;
   int total_cnt = 0;

   instr_fetch_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_instr(a_rsp_instr), .rsp_fault(a_rsp_fault), .flush(a_flush),
      .prog_we(a_prog_we), .prog_addr(a_prog_addr), .prog_wdata(a_prog_wdata)
   );

   instr_fetch_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_instr(b_rsp_instr), .rsp_fault(b_rsp_fault), .flush(b_flush),
      .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_wdata(b_prog_wdata)
   );

   task automatic prog_a(input logic [IW-1:0] idx, input logic [DW-1:0] data);
      a_prog_we = 1'b1; a_prog_addr = idx; a_prog_wdata = data;
      @(negedge clk);
      a_prog_we = 1'b0;
   endtask

   task automatic prog_b(input logic [IW-1:0] idx, input logic [DW-1:0] data);
      b_prog_we = 1'b1; b_prog_addr = idx; b_prog_wdata = data;
      @(negedge clk);
      b_prog_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_req_valid = 1'b1; a_req_addr = 32'h0C; a_rsp_ready = 1'b1;
      b_req_valid = 1'b1; b_req_addr = 32'h0C; b_rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== 35'd0)
         $display("FAIL reset_a: got v=%0b f=%0h i=%h want all zero", a_rsp_valid, a_rsp_fault, a_rsp_instr);
      else pass_cnt++;
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== 35'd0)
         $display("FAIL reset_b: got v=%0b f=%0h i=%h want all zero", b_rsp_valid, b_rsp_fault, b_rsp_instr);
      else pass_cnt++;
      a_req_valid = 1'b0; b_req_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid} !== 4'b1100)
         $display("FAIL reset_release: got rdy=%0b%0b vld=%0b%0b want rdy=11 vld=00",
                  a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_load_fetch();
      prog_a(7'd3, 32'h00500093);
      prog_a(7'd4, 32'h00100113);
      prog_a(7'd5, 32'h002081b3);
      prog_a(7'd127, 32'hCAFEF00D);
      a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_req_addr = 32'h0C;
      a_exp_q.push_back({2'b00, 32'h00500093});
      #1;
      total_cnt++;
      if (a_req_ready !== 1'b1) $display("FAIL load_ready: got %0b want 1", a_req_ready);
      else pass_cnt++;
      @(negedge clk);
      a_req_valid = 1'b0;
      exp_v = a_exp_q.pop_front();
      total_cnt++;
      if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL load_fetch: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  a_rsp_valid, a_rsp_fault, a_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (a_rsp_valid !== 1'b0) $display("FAIL load_drain: got v=%0b want 0", a_rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addr_t [3];
      logic [DW-1:0] data_t [3];
      addr_t = '{32'h0C, 32'h10, 32'h14};
      data_t = '{32'h00500093, 32'h00100113, 32'h002081b3};
      a_rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            exp_v = a_exp_q.pop_front();
            total_cnt++;
            if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== {1'b1, exp_v})
               $display("FAIL b2b[%0d]: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h", i - 1,
                        a_rsp_valid, a_rsp_fault, a_rsp_instr, exp_v[33:32], exp_v[31:0]);
            else pass_cnt++;
         end
         if (i < 3) begin
            a_req_valid = 1'b1; a_req_addr = addr_t[i];
            a_exp_q.push_back({2'b00, data_t[i]});
         end else begin
            a_req_valid = 1'b0;
         end
         @(negedge clk);
      end
      total_cnt++;
      if (a_rsp_valid !== 1'b0) $display("FAIL b2b_drain: got v=%0b want 0", a_rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_faults();
      logic [AW-1:0] addr_t [5];
      logic [33:0]   exp_t  [5];
      addr_t = '{32'h06, 32'h200, 32'h202, 32'h1FC, 32'h8000_0000};
      exp_t  = '{{2'b01, NOP}, {2'b10, NOP}, {2'b01, NOP}, {2'b00, 32'hCAFEF00D}, {2'b10, NOP}};
      a_rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            exp_v = a_exp_q.pop_front();
            total_cnt++;
            if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== {1'b1, exp_v})
               $display("FAIL fault[%0d]: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h", i - 1,
                        a_rsp_valid, a_rsp_fault, a_rsp_instr, exp_v[33:32], exp_v[31:0]);
            else pass_cnt++;
         end
         if (i < 5) begin
            a_req_valid = 1'b1; a_req_addr = addr_t[i];
            a_exp_q.push_back(exp_t[i]);
         end else begin
            a_req_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_latency_backpressure();
      prog_b(7'd3, 32'h00500093);
      prog_b(7'd7, 32'h12345678);
      b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_addr = 32'h0C;
      b_exp_q.push_back({2'b00, 32'h00500093});
      @(negedge clk);
      b_req_addr = 32'h1C;
      for (int i = 0; i < 2; i++) begin
         total_cnt++;
         if ({b_rsp_valid, b_req_ready} !== 2'b00)
            $display("FAIL lat3_wait[%0d]: got v=%0b rdy=%0b want v=0 rdy=0", i, b_rsp_valid, b_req_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         exp_v = b_exp_q[0];
         total_cnt++;
         if ({b_rsp_valid, b_req_ready, b_rsp_fault, b_rsp_instr} !== {2'b10, exp_v})
            $display("FAIL lat3_hold[%0d]: got v=%0b rdy=%0b f=%0h i=%h want v=1 rdy=0 f=%0h i=%h", i,
                     b_rsp_valid, b_req_ready, b_rsp_fault, b_rsp_instr, exp_v[33:32], exp_v[31:0]);
         else pass_cnt++;
         @(negedge clk);
      end
      exp_v = b_exp_q.pop_front();
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL lat3_release: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  b_rsp_valid, b_rsp_fault, b_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      b_rsp_ready = 1'b1;
      b_exp_q.push_back({2'b00, 32'h12345678});
      #1;
      total_cnt++;
      if (b_req_ready !== 1'b1) $display("FAIL lat3_reaccept_ready: got %0b want 1", b_req_ready);
      else pass_cnt++;
      @(negedge clk);
      b_req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         total_cnt++;
         if (b_rsp_valid !== 1'b0) $display("FAIL lat3_second_wait[%0d]: got v=%0b want 0", i, b_rsp_valid);
         else pass_cnt++;
         @(negedge clk);
      end
      exp_v = b_exp_q.pop_front();
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL lat3_second: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  b_rsp_valid, b_rsp_fault, b_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (b_rsp_valid !== 1'b0) $display("FAIL lat3_drain: got v=%0b want 0", b_rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 32'h0C;
      @(negedge clk);
      b_req_valid = 1'b0;
      @(negedge clk);
      b_flush = 1'b1; b_req_valid = 1'b1; b_req_addr = 32'h1C;
      #1;
      total_cnt++;
      if (b_req_ready !== 1'b0) $display("FAIL flush_ready: got %0b want 0", b_req_ready);
      else pass_cnt++;
      @(negedge clk);
      b_flush = 1'b0; b_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (b_rsp_valid !== 1'b0) $display("FAIL flush_quiet[%0d]: got v=%0b want 0", i, b_rsp_valid);
         else pass_cnt++;
         @(negedge clk);
      end
      b_req_valid = 1'b1; b_req_addr = 32'h0C;
      b_exp_q.push_back({2'b00, 32'h00500093});
      @(negedge clk);
      b_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      exp_v = b_exp_q.pop_front();
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL flush_next: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  b_rsp_valid, b_rsp_fault, b_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_collision();
      prog_a(7'd5, 32'hAAAAAAAA);
      a_rsp_ready = 1'b1;
      a_prog_we = 1'b1; a_prog_addr = 7'd5; a_prog_wdata = 32'hBBBBBBBB;
      a_req_valid = 1'b1; a_req_addr = 32'h14;
      a_exp_q.push_back({2'b00, 32'hAAAAAAAA});
      @(negedge clk);
      a_prog_we = 1'b0;
      exp_v = a_exp_q.pop_front();
      total_cnt++;
      if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL collide_old: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  a_rsp_valid, a_rsp_fault, a_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      a_exp_q.push_back({2'b00, 32'hBBBBBBBB});
      @(negedge clk);
      a_req_valid = 1'b0;
      exp_v = a_exp_q.pop_front();
      total_cnt++;
      if ({a_rsp_valid, a_rsp_fault, a_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL collide_new: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  a_rsp_valid, a_rsp_fault, a_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_req_addr = 32'h1C;
      @(negedge clk);
      b_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (b_rsp_valid !== 1'b1) $display("FAIL areset_pre: got v=%0b want 1", b_rsp_valid);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== 35'd0)
         $display("FAIL areset_clear: got v=%0b f=%0h i=%h want all zero", b_rsp_valid, b_rsp_fault, b_rsp_instr);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1; b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 32'h1C;
      b_exp_q.push_back({2'b00, 32'h12345678});
      @(negedge clk);
      b_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      exp_v = b_exp_q.pop_front();
      total_cnt++;
      if ({b_rsp_valid, b_rsp_fault, b_rsp_instr} !== {1'b1, exp_v})
         $display("FAIL areset_mem_kept: got v=%0b f=%0h i=%h want v=1 f=%0h i=%h",
                  b_rsp_valid, b_rsp_fault, b_rsp_instr, exp_v[33:32], exp_v[31:0]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b0; a_flush = 1'b0;
      a_prog_we = 1'b0; a_prog_addr = '0; a_prog_wdata = '0;
      b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0; b_flush = 1'b0;
      b_prog_we = 1'b0; b_prog_addr = '0; b_prog_wdata = '0;
      test_reset();
      test_load_fetch();
      test_back_to_back();
      test_faults();
      test_latency_backpressure();
      test_flush();
      test_collision();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
